// File: rtl/aexm_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// aexm_dmem_ctrl
//   Data-memory responder for the aexm core.
//   - Loads are served from a direct-mapped, write-through, no-write-allocate
//     cache of LINES one-word lines. Hits return data the next cycle with no
//     stall.
//   - Misses (or forced misses) stall the core and refill the line over a
//     req/ack bus.
//   - Stores go through a one-entry write buffer that drains in the background
//     over the same bus port.
//
// Ports
//   gclk, grst                     clock, async active-low reset
//   dSTRLOD, dLOD                  request valid / request is a load
//   dADDR, dDATO, dSEL             byte address, store data, byte enables
//   aexm_dcache_precycle_we        a store follows next cycle
//   aexm_dcache_force_miss         bypass the cache for this load and refill
//   dDATI, dSTALL                  load data / hold the core
//   mREQ, mWE, mADDR, mDATO, mSEL  bus request side (held until mACK)
//   mACK, mDATI                    bus acknowledge pulse / read data
// -----------------------------------------------------------------------------
module aexm_dmem_ctrl #(
   parameter int LINES = 16,
   parameter int IW    = 4
) (
   input  logic        gclk,
   input  logic        grst,
   input  logic        dSTRLOD,
   input  logic        dLOD,
   input  logic [31:0] dADDR,
   input  logic [31:0] dDATO,
   input  logic [3:0]  dSEL,
   input  logic        aexm_dcache_precycle_we,
   input  logic        aexm_dcache_force_miss,
   output logic [31:0] dDATI,
   output logic        dSTALL,
   output logic        mREQ,
   output logic        mWE,
   output logic [31:0] mADDR,
   output logic [31:0] mDATO,
   output logic [3:0]  mSEL,
   input  logic        mACK,
   input  logic [31:0] mDATI
);

   localparam int TW = 32 - IW - 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      RFILL = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Cache storage
   logic [LINES-1:0] valid_q;
   logic [TW-1:0]    tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   // Control / write buffer / bus registers
   state_t      state_q;
   logic        wb_full_q;
   logic        wb_full_d;
   logic [31:0] wb_addr_q;
   logic [31:0] wb_data_q;
   logic [3:0]  wb_sel_q;
   logic [31:0] ld_addr_q;
   logic        mreq_q;
   logic        mwe_q;
   logic [31:0] maddr_q;
   logic [31:0] mdato_q;
   logic [3:0]  msel_q;
   logic        dstall_q;
   logic [31:0] ddati_q;

   // Request decode
   logic [IW-1:0] req_idx;
   logic [TW-1:0] req_tag;
   logic [IW-1:0] ld_idx;
   logic          req_hit;
   logic          idle_like;
   logic          accept;
   logic          ld_acc;
   logic          ld_hit;
   logic          ld_miss;
   logic          st_acc;
   logic          st_blocked;
   logic          st_hit;
   logic          bus_ack;
   logic          wr_ack;
   logic          rd_ack;
   logic [31:0]   st_merged;
   logic          unused_addr_lsb;

   assign req_idx   = dADDR[IW+1:2];
   assign req_tag   = dADDR[31:IW+2];
   assign ld_idx    = ld_addr_q[IW+1:2];
   assign req_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   // DONE accepts new requests just like IDLE; it only differs in lasting one cycle.
   assign idle_like = (state_q == IDLE) || (state_q == DONE);
   assign accept    = dSTRLOD && !dstall_q && idle_like;
   assign ld_acc    = accept && dLOD;
   assign ld_hit    = ld_acc && req_hit && !aexm_dcache_force_miss;
   assign ld_miss   = ld_acc && !(req_hit && !aexm_dcache_force_miss);
   assign st_acc    = accept && !dLOD && !wb_full_q;
   assign st_blocked = dSTRLOD && !dLOD && wb_full_q;
   assign st_hit    = st_acc && req_hit;

   // mACK only counts while a request is actually outstanding.
   assign bus_ack   = mreq_q && mACK;
   assign wr_ack    = bus_ack && mwe_q;
   assign rd_ack    = bus_ack && !mwe_q;

   assign unused_addr_lsb = ^dADDR[1:0];

   // Write buffer occupancy after this edge: a store fills it, a write ack empties it.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      wb_full_d = wb_full_q;
      if (wr_ack) wb_full_d = 1'b0;
      if (st_acc) wb_full_d = 1'b1;
   end

   // Byte-merge of a store into the currently cached word.
   always_comb begin
      st_merged = data_q[req_idx];
      for (int b = 0; b < 4; b++) begin
         if (dSEL[b]) st_merged[8*b +: 8] = dDATO[8*b +: 8];
      end
   end

   // NOTE: tag/data arrays carry no reset; valid_q alone decides whether a line is usable.
   always_ff @(posedge gclk) begin
      if (rd_ack) begin
         tag_q[ld_idx]  <= ld_addr_q[31:IW+2];
         data_q[ld_idx] <= mDATI;
      end else if (st_hit) begin
         data_q[req_idx] <= st_merged;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
   always_ff @(posedge gclk or negedge grst) begin
      if (!grst) begin
         state_q   <= IDLE;
         valid_q   <= '0;
         wb_full_q <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         wb_sel_q  <= '0;
         ld_addr_q <= '0;
         mreq_q    <= 1'b0;
         mwe_q     <= 1'b0;
         maddr_q   <= '0;
         mdato_q   <= '0;
         msel_q    <= '0;
         dstall_q  <= 1'b0;
         ddati_q   <= '0;
      end else begin
         // Write buffer capture
         wb_full_q <= wb_full_d;
         if (st_acc) begin
            wb_addr_q <= {dADDR[31:2], 2'b00};
            wb_data_q <= dDATO;
            wb_sel_q  <= dSEL;
         end

         // Shared bus port: one transaction at a time, buffered store has priority
         // so a refill always observes earlier stores.
         if (bus_ack) begin
            mreq_q <= 1'b0;
            mwe_q  <= 1'b0;
         end else if (!mreq_q) begin
            if (wb_full_q) begin
               mreq_q  <= 1'b1;
               mwe_q   <= 1'b1;
               maddr_q <= wb_addr_q;
               mdato_q <= wb_data_q;
               msel_q  <= wb_sel_q;
            end else if (state_q == RFILL) begin
               mreq_q  <= 1'b1;
               mwe_q   <= 1'b0;
               maddr_q <= ld_addr_q;
               msel_q  <= 4'hF;
            end
         end

         if (rd_ack) valid_q[ld_idx] <= 1'b1;

         case (state_q)
            IDLE, DONE: begin
               state_q  <= IDLE;
               // Hold the core while a store cannot enter the (still) full buffer;
               // precycle_we raises the stall before the second store shows up.
               dstall_q <= wb_full_d && (st_blocked || aexm_dcache_precycle_we || dstall_q);
               if (ld_hit) begin
                  ddati_q <= data_q[req_idx];
               end else if (ld_miss) begin
                  ld_addr_q <= {dADDR[31:2], 2'b00};
                  dstall_q  <= 1'b1;
                  state_q   <= wb_full_d ? DRAIN : RFILL;
               end
            end
            DRAIN: begin
               if (!wb_full_d) state_q <= RFILL;
            end
            RFILL: begin
               if (rd_ack) begin
                  ddati_q  <= mDATI;
                  dstall_q <= 1'b0;
                  state_q  <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dDATI  = ddati_q;
   assign dSTALL = dstall_q;
   assign mREQ   = mreq_q;
   assign mWE    = mwe_q;
   assign mADDR  = maddr_q;
   assign mDATO  = mdato_q;
   assign mSEL   = msel_q;

endmodule

// File: doc/aexm_dmem_ctrl.md
Name: aexm_dmem_ctrl

Overview:
- Data-memory responder for the aexm core.
- Accepts load/store requests from the decode/control stage: dSTRLOD, dLOD, aexm_dcache_precycle_we, aexm_dcache_force_miss, plus address, data and byte selects.
- Serves loads from a small direct-mapped, write-through, no-write-allocate data cache.
- Forwards misses and stores to a req/ack memory bus through a one-entry write buffer, and stalls the core while a request is outstanding.

Parameters:
- LINES, 16, number of one-word cache lines; must be a power of two, minimum 2.
- IW, 4, log2(LINES); index is dADDR[IW+1:2].

Ports:
- gclk  in  1  system clock; all state on posedge.
- grst  in  1  reset; asynchronous, active-low.
- dSTRLOD  in  1  load or store request this cycle.
- dLOD  in  1  request is a load (else a store); valid only with dSTRLOD.
- dADDR  in  32  byte address; word-aligned, bits [1:0] ignored.
- dDATO  in  32  store data.
- dSEL  in  4  byte enables; bit 3 = dDATO[31:24].
- aexm_dcache_precycle_we  in  1  a store will be presented next cycle.
- aexm_dcache_force_miss  in  1  treat the current load as a miss; bypass and refill.
- dDATI  out  32  load data.
- dSTALL  out  1  core must hold its request and pipeline.
- mREQ  out  1  bus request.
- mWE  out  1  bus write.
- mADDR  out  32  bus word address; [1:0] = 0.
- mDATO  out  32  bus write data.
- mSEL  out  4  bus byte enables.
- mACK  in  1  bus acknowledge; one-cycle pulse.
- mDATI  in  32  bus read data; valid with mACK.

Behaviour:
- Reset (grst low, asynchronous):
  - all valid bits 0; write buffer empty; FSM in IDLE;
  - dSTALL 0, mREQ 0, mWE 0, mADDR 0, mDATO 0, mSEL 0, dDATI 0.
  - Reset during an outstanding bus cycle abandons it; a late mACK is ignored.
- Request acceptance: a request is accepted on a posedge with dSTRLOD=1 and dSTALL=0.
- Load hit (line valid, tag = dADDR[31:IW+2], force_miss=0):
  - dDATI = line data on the next cycle;
  - dSTALL stays 0; zero added latency.
- Load miss, or force_miss=1:
  - dSTALL=1 from the cycle after acceptance.
  - If the write buffer is full, state DRAIN: write the buffer to the bus first (load after store ordering), then go to RFILL.
  - RFILL: mREQ=1, mWE=0, mSEL=4'hF; address held stable until mACK.
  - On mACK: write line data and tag, set valid, latch dDATI=mDATI.
  - Go to DONE; dSTALL=0 in DONE. DONE lasts one cycle, then IDLE.
- Store:
  - Accepted only if the write buffer is empty; it captures address, data and sel.
  - On a hit, the cached word's selected bytes are updated in the same cycle.
  - A miss leaves the cache unchanged.
  - The buffer drains in the background: mREQ=1, mWE=1 until mACK, then it is empty.
  - Store acceptance never stalls when the buffer is empty.
- Back-to-back store:
  - If aexm_dcache_precycle_we=1 while the buffer is full, dSTALL rises on the next cycle and stays high until the drain mACK.
  - The same holds if dSTRLOD store arrives with the buffer full.
  - dSTALL falls the cycle after mACK; the held store is then accepted.
- Bus protocol:
  - mREQ, mWE, mADDR, mDATO and mSEL are stable from assertion until the cycle mACK is sampled.
  - mREQ drops the following cycle; there is at most one outstanding transaction.
  - mACK is ignored while mREQ=0.
- Simultaneous events:
  - A drain ack and a new load in the same cycle: the load's hit check uses the updated cache.
  - A drain store and a refill of the same index: refill data wins, since its ack comes later.
- FSM states: IDLE, DRAIN, RFILL, DONE.
  - The background store drain runs from IDLE and uses the same bus port.
  - RFILL waits for the drain's ack before issuing its request.

Test Plan:
- Cold load at 0x0000_0040, bus returns 0xDEADBEEF after 3 cycles -> dSTALL high 4 cycles, dDATI=0xDEADBEEF, one mREQ read at 0x40; repeat load -> hit, no mREQ, dSTALL stays 0.
- Load 0x40 with force_miss=1 after it is cached, bus returns 0x12345678 -> bus read issued, dDATI=0x12345678, next plain load hits with 0x12345678.
- Store 0xAABBCCDD sel=4'b0011 to cached 0x40 (0xDEADBEEF) -> write-through mWE=1 mSEL=3; a following load hits with 0xDEADCCDD.
- Two stores on consecutive cycles with mACK delayed 5 cycles -> precycle_we raises dSTALL the next cycle; second store is issued only after the first ack; bus order is preserved.
- Store to 0x80 pending in the buffer, then load miss at 0x80 -> bus write precedes bus read; loaded value reflects the bus.
- grst low during RFILL, mACK arriving after release -> outputs at reset values, valid bits clear, stray mACK ignored, next load misses.
